// File: rtl/usb_tx_bit_sequencer.sv
// USB TX bit sequencer: paces the parallel-to-serial shift register at BIT_PERIOD clocks per bit,
// inserts a stuff slot after STUFF_LEN consecutive ones, and flags end-of-packet or underrun.
module usb_tx_bit_sequencer #(
    parameter int BIT_PERIOD = 8,
    parameter int STUFF_LEN  = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic byte_valid,
    input  logic last_byte,
    input  logic data_bit,
    output logic byte_ready,
    output logic load_enable,
    output logic shift_enable,
    output logic bit_strobe,
    output logic stuff_active,
    output logic tx_active,
    output logic eop_start,
    output logic underrun
);

    localparam int CW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam int OW = (STUFF_LEN > 1) ? $clog2(STUFF_LEN + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STUFF} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_cnt;
    logic [OW-1:0]   r_ones_cnt;
    logic            r_last_q;

    logic w_slot_end;
    logic w_data_end;
    logic w_stuff_now;
    logic w_adv;
    logic w_more;
    logic w_byte_done;
    logic w_next_load;
    logic w_under;
    logic w_eop;
    logic w_start;

    always_comb begin
        w_slot_end  = (r_state != S_IDLE) && (r_clk_cnt == CW'(BIT_PERIOD - 1));
        w_data_end  = (r_state == S_DATA) && w_slot_end;
        // The one that completes a run of STUFF_LEN diverts this slot end into a stuff slot.
        w_stuff_now = w_data_end && data_bit && (r_ones_cnt == OW'(STUFF_LEN - 1));
        w_adv       = w_slot_end && !w_stuff_now;
        w_more      = w_adv && (r_bit_cnt != 3'd7);
        w_byte_done = w_adv && (r_bit_cnt == 3'd7);
        w_next_load = w_byte_done && !r_last_q && byte_valid;
        w_under     = w_byte_done && !r_last_q && !byte_valid;
        w_eop       = w_byte_done && r_last_q;
        // Gated by n_rst so no handshake is seen while reset is held.
        w_start     = (r_state == S_IDLE) && byte_valid && n_rst;
    end

    assign load_enable  = w_start || w_next_load;
    assign byte_ready   = load_enable;
    assign shift_enable = w_more;
    assign bit_strobe   = (r_state != S_IDLE) && (r_clk_cnt == '0);
    assign stuff_active = (r_state == S_STUFF);
    assign tx_active    = (r_state != S_IDLE);
    assign eop_start    = w_eop;
    assign underrun     = w_under;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_last_q   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ones_cnt <= '0;
                    r_clk_cnt  <= '0;
                    r_bit_cnt  <= '0;
                    if (byte_valid) begin
                        r_state  <= S_DATA;
                        r_last_q <= last_byte;
                    end
                end
                S_DATA, S_STUFF: begin
                    if (!w_slot_end) begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end else begin
                        r_clk_cnt <= '0;
                        if (w_data_end) begin
                            r_ones_cnt <= data_bit ? (r_ones_cnt + OW'(1)) : '0;
                        end
                        if (w_stuff_now) begin
                            // Bit position is held; the pending shift/load happens at the stuff slot end.
                            r_state    <= S_STUFF;
                            r_ones_cnt <= '0;
                        end else if (w_more) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (w_next_load) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_last_q  <= last_byte;
                        end else begin
                            r_state    <= S_IDLE;
                            r_ones_cnt <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_bit_sequencer.sv
// Directed bench for usb_tx_bit_sequencer with BIT_PERIOD=8, STUFF_LEN=6; k counts cycles from the first load.
module tb_usb_tx_bit_sequencer;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic byte_valid = 1'b0;
    logic last_byte = 1'b0;
    logic data_bit = 1'b0;
    logic byte_ready, load_enable, shift_enable, bit_strobe;
    logic stuff_active, tx_active, eop_start, underrun;

    int n_cmp = 0;
    int n_err = 0;

    usb_tx_bit_sequencer #(.BIT_PERIOD(8), .STUFF_LEN(6)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .byte_valid(byte_valid),
        .last_byte(last_byte),
        .data_bit(data_bit),
        .byte_ready(byte_ready),
        .load_enable(load_enable),
        .shift_enable(shift_enable),
        .bit_strobe(bit_strobe),
        .stuff_active(stuff_active),
        .tx_active(tx_active),
        .eop_start(eop_start),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Vector order: {byte_ready, load_enable, shift_enable, bit_strobe, stuff_active, tx_active, eop_start, underrun}
    task automatic chk(input string tag, input int k, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {byte_ready, load_enable, shift_enable, bit_strobe,
               stuff_active, tx_active, eop_start, underrun};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    // Hand-derived event times per scenario:
    // 0 single byte zeros; 1 single byte ones; 2 two bytes zeros; 3 byte-boundary stuff; 4 underrun.
    function automatic logic [7:0] expv(input int s, input int k);
        logic ld, sh, st, sf, tx, eo, ur;
        ld = 0; sh = 0; st = 0; sf = 0; tx = 0; eo = 0; ur = 0;
        case (s)
            0: begin
                ld = (k == 0);
                st = (k >= 1) && (k <= 57) && (k % 8 == 1);
                sh = (k >= 8) && (k <= 56) && (k % 8 == 0);
                tx = (k >= 1) && (k <= 64);
                eo = (k == 64);
            end
            1: begin
                ld = (k == 0);
                st = (k >= 1) && (k <= 65) && (k % 8 == 1);
                sh = (k >= 8) && (k <= 64) && (k % 8 == 0) && (k != 48);
                sf = (k >= 49) && (k <= 56);
                tx = (k >= 1) && (k <= 72);
                eo = (k == 72);
            end
            2: begin
                ld = (k == 0) || (k == 64);
                st = (k >= 1) && (k <= 121) && (k % 8 == 1);
                sh = (k >= 8) && (k <= 120) && (k % 8 == 0) && (k != 64);
                tx = (k >= 1) && (k <= 128);
                eo = (k == 128);
            end
            3: begin
                ld = (k == 0) || (k == 72);
                st = (k >= 1) && (k <= 129) && (k % 8 == 1);
                sh = (k % 8 == 0) && (((k >= 8) && (k <= 56)) || ((k >= 80) && (k <= 128)));
                sf = (k >= 65) && (k <= 72);
                tx = (k >= 1) && (k <= 136);
                eo = (k == 136);
            end
            default: begin
                ld = (k == 0);
                st = (k >= 1) && (k <= 57) && (k % 8 == 1);
                sh = (k >= 8) && (k <= 56) && (k % 8 == 0);
                tx = (k >= 1) && (k <= 64);
                ur = (k == 64);
            end
        endcase
        return {ld, ld, sh, st, sf, tx, eo, ur};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input int k);
        if (k == 0) begin
            byte_valid = 1'b1;
            last_byte  = (s == 0) || (s == 1);
        end else if (k == 1) begin
            byte_valid = 1'b0;
        end
        if ((s == 2 || s == 3) && k == 10) begin
            byte_valid = 1'b1;
            last_byte  = 1'b1;
        end
        if ((s == 2 && k == 65) || (s == 3 && k == 73)) byte_valid = 1'b0;
        case (s)
            1:       data_bit = 1'b1;
            3:       data_bit = (k >= 17) && (k <= 72);
            default: data_bit = 1'b0;
        endcase
    endtask

    task automatic run(input int s, input int last_k, input string tag);
        for (int k = 0; k <= last_k; k++) begin
            drive(s, k);
            #1;
            chk(tag, k, expv(s, k));
            tick();
        end
        byte_valid = 1'b0;
        data_bit   = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            chk(tag, i, 8'h00);
            tick();
        end
    endtask

    initial begin
        #2;
        chk("reset", 0, 8'h00);
        tick();
        n_rst = 1'b1;
        tick();
        idle(3, "idle_start");

        run(0, 66, "single_zeros");
        idle(2, "gap0");
        run(1, 74, "single_ones");
        idle(2, "gap1");
        run(2, 130, "two_bytes");
        idle(2, "gap2");
        run(3, 138, "boundary_stuff");
        idle(2, "gap3");
        run(4, 66, "underrun");
        idle(2, "gap4");

        for (int k = 0; k <= 20; k++) begin
            drive(1, k);
            #1;
            chk("pre_abort", k, expv(1, k));
            if (k < 20) tick();
        end
        byte_valid = 1'b1;
        n_rst = 1'b0;
        #1;
        chk("abort_now", 20, 8'h00);
        tick();
        chk("abort_held", 21, 8'h00);
        byte_valid = 1'b0;
        n_rst = 1'b1;
        tick();
        idle(2, "after_abort");
        run(1, 74, "restart_ones");
        idle(2, "gap5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
